// File: rtl/clk_enable_gen.sv
// Multi-channel numerically-controlled clock-enable generator: each channel adds
// inc to a phase accumulator and emits its carry as a one-cycle enable pulse.
module clk_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                    clkin,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic [NUM_CH*ACC_W-1:0] phase,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       ce_p,
  output logic [NUM_CH-1:0]       clk_sq,
  output logic                    lock
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [ACC_W-1:0]  inc_q   [NUM_CH];
  logic [ACC_W-1:0]  acc_q   [NUM_CH];
  logic [ACC_W-1:0]  accp_q  [NUM_CH];
  logic [ACC_W:0]    sum_d   [NUM_CH];
  logic [ACC_W:0]    sump_d  [NUM_CH];
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] ce_p_q;
  logic [NUM_CH-1:0] clk_sq_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lock_q;

  // One extra bit on the sum captures the wrap, which is the enable pulse.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum_d[i]  = {1'b0, acc_q[i]}  + {1'b0, inc_q[i]};
      sump_d[i] = {1'b0, accp_q[i]} + {1'b0, inc_q[i]};
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i]  <= '0;
        acc_q[i]  <= '0;
        accp_q[i] <= '0;
      end
      ce_q     <= '0;
      ce_p_q   <= '0;
      clk_sq_q <= '0;
      cnt_q    <= '0;
      lock_q   <= 1'b0;
    end else if (load) begin
      // The offset accumulator starts at the phase value; that head start is the lead.
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i]  <= inc[i*ACC_W +: ACC_W];
        acc_q[i]  <= '0;
        accp_q[i] <= phase[i*ACC_W +: ACC_W];
      end
      ce_q     <= '0;
      ce_p_q   <= '0;
      clk_sq_q <= '0;
      cnt_q    <= '0;
      lock_q   <= 1'b0;
    end else begin
      if (enable) begin
        for (int i = 0; i < NUM_CH; i++) begin
          acc_q[i]    <= sum_d[i][ACC_W-1:0];
          accp_q[i]   <= sump_d[i][ACC_W-1:0];
          ce_q[i]     <= sum_d[i][ACC_W];
          ce_p_q[i]   <= sump_d[i][ACC_W];
          clk_sq_q[i] <= sum_d[i][ACC_W-1];
        end
        if (cnt_q != LOCK_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        ce_q   <= '0;
        ce_p_q <= '0;
      end
      if (cnt_q == LOCK_MAX) lock_q <= 1'b1;
    end
  end

  assign ce     = ce_q;
  assign ce_p   = ce_p_q;
  assign clk_sq = clk_sq_q;
  assign lock   = lock_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clk_enable_gen;
  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 24;
  localparam int LOCK_CYCLES = 256;

  localparam logic [6:0] M_CE0  = 7'h01;
  localparam logic [6:0] M_CE1  = 7'h02;
  localparam logic [6:0] M_CEP0 = 7'h04;
  localparam logic [6:0] M_CEP1 = 7'h08;
  localparam logic [6:0] M_SQ0  = 7'h10;
  localparam logic [6:0] M_SQ1  = 7'h20;
  localparam logic [6:0] M_LOCK = 7'h40;
  localparam logic [6:0] M_ALL  = 7'h7F;

  logic clkin = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [NUM_CH*ACC_W-1:0] inc = '0;
  logic [NUM_CH*ACC_W-1:0] phase = '0;
  logic [NUM_CH-1:0] ce, ce_p, clk_sq;
  logic lock;
  logic [6:0] obs;

  clk_enable_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clkin(clkin), .reset_n(reset_n), .enable(enable), .load(load),
    .inc(inc), .phase(phase), .ce(ce), .ce_p(ce_p), .clk_sq(clk_sq), .lock(lock)
  );

  always #5 clkin = ~clkin;

  assign obs = {lock, clk_sq, ce_p, ce};

  typedef struct {
    int               cyc;
    logic [6:0]       mask;
    logic [6:0]       val;
    logic [8*12-1:0]  nm;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      n_cmp++;
      if (m_e.cyc < cyc) begin
        n_mis++;
        $display("FAIL %s stale entry for edge %0d at edge %0d", m_e.nm, m_e.cyc, cyc);
      end else if ((obs & m_e.mask) !== m_e.val) begin
        n_mis++;
        $display("FAIL %s edge %0d: got %b want %b (mask %b)", m_e.nm, cyc,
                 obs & m_e.mask, m_e.val, m_e.mask);
      end
    end
  end

  task automatic push(input int rel, input logic [6:0] mask, input logic [6:0] val,
                      input logic [8*12-1:0] nm);
    exp_t e;
    e.cyc = cyc + rel;
    e.mask = mask;
    e.val = val;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int cnt;
    int last;
    int bad;
    logic [6:0] v;

    // Reset state
    step();
    step();
    push(1, M_ALL, 7'h00, "reset");
    step();
    reset_n = 1'b1;

    // Quarter rate with half-period phase lead on channel 0
    inc   = {24'h000000, 24'h400000};
    phase = {24'h000000, 24'h800000};
    load = 1'b1;
    enable = 1'b1;
    push(1, M_ALL, 7'h00, "load_q");
    for (int k = 1; k <= 12; k++) begin
      v = '0;
      v[0] = (k % 4 == 0);
      v[2] = (k % 4 == 2);
      v[4] = (k % 4 == 2) || (k % 4 == 3);
      push(1 + k, 7'h3F, v, "quarter");
    end
    step();
    load = 1'b0;
    repeat (12) step();

    // Freeze for 50 cycles after 100 enabled ones; lock counts only enabled cycles
    inc   = {24'h000000, 24'h400000};
    phase = '0;
    load = 1'b1;
    push(1, M_CE0 | M_LOCK, 7'h00, "load_frz");
    for (int t = 1; t <= 310; t++) begin
      int k;
      k = (t <= 100) ? t : ((t > 150) ? t - 50 : 0);
      v = '0;
      v[0] = (k != 0) && (k % 4 == 0);
      v[6] = (t >= 307);
      push(1 + t, M_CE0 | M_LOCK, v, "freeze");
    end
    step();
    load = 1'b0;
    cnt = 0;
    for (int t = 1; t <= 310; t++) begin
      enable = (t <= 100) || (t > 150);
      step();
      if (ce[0]) cnt++;
    end
    check("freeze_pulse_count", cnt, 65);

    // Load on the very cycle a carry is due: no pulse, restart, relock
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) push(k, M_CE0 | M_LOCK, M_LOCK, "pre_collide");
    push(4, M_CE0 | M_CEP0 | M_LOCK, 7'h00, "collide");
    for (int k = 1; k <= 260; k++) begin
      v = '0;
      v[0] = (k % 4 == 0);
      v[6] = (k >= 257);
      push(4 + k, M_CE0 | M_LOCK, v, "relock");
    end
    repeat (3) step();
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (260) step();

    // MSX tick: 72 MHz * 834094 / 2^24
    inc   = {24'h0CBA2E, 24'h400000};
    phase = '0;
    load = 1'b1;
    push(1, M_CE1 | M_CEP1 | M_SQ1, 7'h00, "load_msx");
    for (int k = 1; k <= 21; k++)
      push(1 + k, M_CE1 | M_CEP1, (k == 21) ? (M_CE1 | M_CEP1) : 7'h00, "msx_first");
    step();
    load = 1'b0;
    cnt = 0;
    last = -1;
    bad = 0;
    for (int k = 1; k <= 72000; k++) begin
      step();
      if (ce[1]) begin
        if (last >= 0 && (k - last < 20 || k - last > 21)) bad++;
        last = k;
        cnt++;
      end
    end
    n_cmp++;
    if (cnt != 3579 && cnt != 3580) begin
      n_mis++;
      $display("FAIL msx_count: got %0d want 3579 or 3580", cnt);
    end
    check("msx_bad_gaps", bad, 0);

    // Zero increment on channel 1, half rate on channel 0
    inc   = {24'h000000, 24'h800000};
    phase = '0;
    load = 1'b1;
    push(1, M_ALL, 7'h00, "load_zero");
    for (int k = 1; k <= 10000; k++) begin
      v = '0;
      v[0] = (k % 2 == 0);
      v[2] = (k % 2 == 0);
      v[4] = (k % 2 == 1);
      v[6] = (k >= 257);
      push(1 + k, M_ALL, v, "zero_inc");
    end
    step();
    load = 1'b0;
    repeat (10000) step();

    // Mid-run reset while locked and pulsing
    reset_n = 1'b0;
    push(1, M_ALL, 7'h00, "mid_reset");
    for (int k = 1; k <= 30; k++) push(1 + k, M_ALL, 7'h00, "post_reset");
    step();
    reset_n = 1'b1;
    repeat (30) step();

    repeat (2) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
